alu_resp_checker: RTL and testbench

- Response-side companion to the 64-bit ALU operators: consumes (op, a, b, y) tuples from a DUT/stimulus stream over a valid/ready handshake.
- Recomputes the expected result and compares it against y. Counts passes and fails, and latches the first mismatch for debug.
- Synthesizable; sits behind the ALU in self-checking builds and FPGA bring-up.

---
 rtl/alu_resp_checker_if.sv | 12 +
 rtl/alu_resp_checker.sv | 132 +++++++++++++
 tb/tb_alu_resp_checker.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_resp_checker_if.sv
// Tuple stream carrying (op, a, b, y) from an ALU under test into the response checker.
interface alu_resp_checker_if #(parameter int WIDTH = 64);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] y;

  modport master (output in_valid, op, a, b, y, input in_ready);
  modport slave  (input in_valid, op, a, b, y, output in_ready);
endinterface

// File: rtl/alu_resp_checker.sv
// Recomputes ALU results for a tuple stream, counts pass/fail and captures the first mismatch.
// Optional feature macro: ALU_CHK_SUB_EN (op 100 = SUB when defined, illegal otherwise).
module alu_resp_checker #(
  parameter int WIDTH       = 64,
  parameter int CNT_W       = 16,
  parameter bit STOP_ON_ERR = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  alu_resp_checker_if.slave   bus,
  input  logic                clear,
  output logic [CNT_W-1:0]    pass_cnt,
  output logic [CNT_W-1:0]    fail_cnt,
  output logic                err,
  output logic                halted,
  output logic [2:0]          err_op,
  output logic [WIDTH-1:0]    err_a,
  output logic [WIDTH-1:0]    err_b,
  output logic [WIDTH-1:0]    err_y,
  output logic [WIDTH-1:0]    err_exp
);

  typedef enum logic {S_RUN = 1'b0, S_HALT = 1'b1} state_t;

  typedef struct packed {
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] y;
  } tuple_t;

  state_t           state_q, state_d;
  logic             stg_vld_q;
  tuple_t           stg_q;
  logic [CNT_W-1:0] pass_q, fail_q;
  logic             err_q;
  tuple_t           cap_q;
  logic [WIDTH-1:0] cap_exp_q;

  logic [WIDTH-1:0] exp_w;
  logic             legal_w, fail_w, pass_w, accept_w, ready_w;

  // Reference result of the staged tuple; illegal ops yield 0 as the expected value.
  always_comb begin
    exp_w   = '0;
    legal_w = 1'b1;
    case (stg_q.op)
      3'b000:  exp_w = stg_q.a & stg_q.b;
      3'b001:  exp_w = stg_q.a | stg_q.b;
      3'b010:  exp_w = stg_q.a ^ stg_q.b;
      3'b011:  exp_w = stg_q.a + stg_q.b;
`ifdef ALU_CHK_SUB_EN
      3'b100:  exp_w = stg_q.a - stg_q.b;
`else
      3'b100:  legal_w = 1'b0;
`endif
      default: legal_w = 1'b0;
    endcase
  end

  assign fail_w   = stg_vld_q && (!legal_w || (exp_w != stg_q.y));
  assign pass_w   = stg_vld_q && !fail_w;
  assign accept_w = bus.in_valid && ready_w;

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_RUN;
    else        state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    if (clear)                                          state_d = S_RUN;
    else if (state_q == S_RUN && fail_w && STOP_ON_ERR) state_d = S_HALT;
  end

  // FSM: outputs; a failing stage blocks the next tuple so nothing slips in behind it
  always_comb begin
    ready_w = rst_n && !clear && (state_q == S_RUN) && !(STOP_ON_ERR && fail_w);
    halted  = (state_q == S_HALT);
  end

  assign bus.in_ready = ready_w;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg_vld_q <= 1'b0;
      stg_q     <= '0;
    end else if (clear) begin
      stg_vld_q <= 1'b0;
      stg_q     <= '0;
    end else begin
      stg_vld_q <= accept_w;
      if (accept_w) stg_q <= '{op: bus.op, a: bus.a, b: bus.b, y: bus.y};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass_q    <= '0;
      fail_q    <= '0;
      err_q     <= 1'b0;
      cap_q     <= '0;
      cap_exp_q <= '0;
    end else if (clear) begin
      pass_q    <= '0;
      fail_q    <= '0;
      err_q     <= 1'b0;
      cap_q     <= '0;
      cap_exp_q <= '0;
    end else begin
      if (pass_w && pass_q != '1) pass_q <= pass_q + CNT_W'(1);
      if (fail_w && fail_q != '1) fail_q <= fail_q + CNT_W'(1);
      if (fail_w) err_q <= 1'b1;
      if (fail_w && !err_q) begin
        cap_q     <= stg_q;
        cap_exp_q <= exp_w;
      end
    end
  end

  assign pass_cnt = pass_q;
  assign fail_cnt = fail_q;
  assign err      = err_q;
  assign err_op   = cap_q.op;
  assign err_a    = cap_q.a;
  assign err_b    = cap_q.b;
  assign err_y    = cap_q.y;
  assign err_exp  = cap_exp_q;

endmodule

// File: tb/tb_alu_resp_checker.sv
// Bench: halting checker (ua), free-running checker (ub) and a 4-bit-counter twin (uc) fed ub's stream.
module tb_alu_resp_checker;
  localparam int W = 64;

  logic clk, rst_n, clr_a, clr_b;
  int checks, errors;

  alu_resp_checker_if #(.WIDTH(W)) ifa ();
  alu_resp_checker_if #(.WIDTH(W)) ifb ();
  alu_resp_checker_if #(.WIDTH(W)) ifc ();

  assign ifc.in_valid = ifb.in_valid;
  assign ifc.op       = ifb.op;
  assign ifc.a        = ifb.a;
  assign ifc.b        = ifb.b;
  assign ifc.y        = ifb.y;

  logic [15:0]  pa_pass, pa_fail, pb_pass, pb_fail;
  logic [3:0]   pc_pass, pc_fail;
  logic         pa_err, pa_halt, pb_err, pb_halt, pc_err, pc_halt;
  logic [2:0]   pa_op, pb_op, pc_op;
  logic [W-1:0] pa_a, pa_b, pa_y, pa_exp, pb_a, pb_b, pb_y, pb_exp, pc_a, pc_b, pc_y, pc_exp;

  alu_resp_checker #(.WIDTH(W), .CNT_W(16), .STOP_ON_ERR(1'b1)) ua (
    .clk(clk), .rst_n(rst_n), .bus(ifa), .clear(clr_a),
    .pass_cnt(pa_pass), .fail_cnt(pa_fail), .err(pa_err), .halted(pa_halt),
    .err_op(pa_op), .err_a(pa_a), .err_b(pa_b), .err_y(pa_y), .err_exp(pa_exp));

  alu_resp_checker #(.WIDTH(W), .CNT_W(16), .STOP_ON_ERR(1'b0)) ub (
    .clk(clk), .rst_n(rst_n), .bus(ifb), .clear(clr_b),
    .pass_cnt(pb_pass), .fail_cnt(pb_fail), .err(pb_err), .halted(pb_halt),
    .err_op(pb_op), .err_a(pb_a), .err_b(pb_b), .err_y(pb_y), .err_exp(pb_exp));

  alu_resp_checker #(.WIDTH(W), .CNT_W(4), .STOP_ON_ERR(1'b0)) uc (
    .clk(clk), .rst_n(rst_n), .bus(ifc), .clear(clr_b),
    .pass_cnt(pc_pass), .fail_cnt(pc_fail), .err(pc_err), .halted(pc_halt),
    .err_op(pc_op), .err_a(pc_a), .err_b(pc_b), .err_y(pc_y), .err_exp(pc_exp));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    string      nm;
    logic [2:0] op;
    logic [63:0] a, b, y;
    bit         ok;
    logic [63:0] ex;
  } vec_t;
  vec_t vt[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, req);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic put_a(input bit v, input logic [2:0] op, input logic [63:0] a, b, y);
    ifa.in_valid = v; ifa.op = op; ifa.a = a; ifa.b = b; ifa.y = y;
  endtask

  task automatic put_b(input bit v, input logic [2:0] op, input logic [63:0] a, b, y);
    ifb.in_valid = v; ifb.op = op; ifb.a = a; ifb.b = b; ifb.y = y;
  endtask

  task automatic pulse_clr_a();
    clr_a = 1'b1; cyc(); clr_a = 1'b0;
  endtask

  task automatic pulse_clr_b();
    clr_b = 1'b1; cyc(); clr_b = 1'b0;
  endtask

  // Golden result straight from the operator definitions.
  function automatic logic [63:0] ref_exp(input logic [2:0] op, input logic [63:0] a, b,
                                          output bit legal);
    legal = 1'b1;
    case (op)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return a ^ b;
      3'd3: return a + b;
`ifdef ALU_CHK_SUB_EN
      3'd4: return a - b;
`endif
      default: begin legal = 1'b0; return 64'd0; end
    endcase
  endfunction

  function automatic void add_vec(input string nm, input logic [2:0] op,
                                  input logic [63:0] a, b, y, input bit ok, input logic [63:0] ex);
    vec_t v;
    v.nm = nm; v.op = op; v.a = a; v.b = b; v.y = y; v.ok = ok; v.ex = ex;
    vt.push_back(v);
  endfunction

  // Model state for the free-running checker.
  int unsigned m_pass, m_fail;
  bit          m_err;
  logic [2:0]  m_op;
  logic [63:0] m_a, m_exp;

  function automatic void model_take(input logic [2:0] op, input logic [63:0] a, b, y);
    bit lg;
    logic [63:0] e;
    e = ref_exp(op, a, b, lg);
    if (lg && e == y) m_pass++;
    else begin
      m_fail++;
      if (!m_err) begin m_op = op; m_a = a; m_exp = e; end
      m_err = 1'b1;
    end
  endfunction

  function automatic void model_clear();
    m_pass = 0; m_fail = 0; m_err = 1'b0; m_op = '0; m_a = '0; m_exp = '0;
  endfunction

  initial begin
    checks = 0; errors = 0;
    rst_n = 1'b0; clr_a = 1'b0; clr_b = 1'b0;
    put_a(1'b0, 3'd0, 64'd0, 64'd0, 64'd0);
    put_b(1'b0, 3'd0, 64'd0, 64'd0, 64'd0);

    add_vec("and",      3'd0, 64'h405, 64'h403, 64'h401, 1'b1, 64'h0);
    add_vec("or",       3'd1, 64'hF0, 64'h0F, 64'hFF, 1'b1, 64'h0);
    add_vec("xor_bad",  3'd2, 64'h5D9F, 64'hF0CB2, 64'h0, 1'b0, 64'hF512D);
    add_vec("add_wrap", 3'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b1, 64'h0);
`ifdef ALU_CHK_SUB_EN
    add_vec("sub",      3'd4, 64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'h0);
`else
    add_vec("sub_ill",  3'd4, 64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'h0);
`endif
    add_vec("ill7",     3'd7, 64'd5, 64'd6, 64'd0, 1'b0, 64'h0);
    add_vec("add_bad",  3'd3, 64'd2, 64'd2, 64'd5, 1'b0, 64'd4);

    // Reset state
    repeat (2) cyc();
    chk("rst_pass", 64'(pa_pass), 64'd0);
    chk("rst_fail", 64'(pa_fail), 64'd0);
    chk("rst_err", 64'(pa_err), 64'd0);
    chk("rst_halt", 64'(pa_halt), 64'd0);
    chk("rst_errexp", pa_exp, 64'd0);
    chk("rst_ready", 64'(ifa.in_ready), 64'd0);
    rst_n = 1'b1;
    #1;
    chk("rst_ready_rel", 64'(ifa.in_ready), 64'd1);
    cyc();

    // Table vectors on the halting checker, each from a clean state
    foreach (vt[i]) begin
      pulse_clr_a();
      put_a(1'b1, vt[i].op, vt[i].a, vt[i].b, vt[i].y);
      cyc();
      ifa.in_valid = 1'b0;
      cyc();
      chk({vt[i].nm, "_pass"}, 64'(pa_pass), vt[i].ok ? 64'd1 : 64'd0);
      chk({vt[i].nm, "_fail"}, 64'(pa_fail), vt[i].ok ? 64'd0 : 64'd1);
      chk({vt[i].nm, "_err"},  64'(pa_err),  vt[i].ok ? 64'd0 : 64'd1);
      chk({vt[i].nm, "_halt"}, 64'(pa_halt), vt[i].ok ? 64'd0 : 64'd1);
      chk({vt[i].nm, "_exp"},  pa_exp, vt[i].ex);
    end

    // Failure halts; following tuple is held off until clear
    pulse_clr_a();
    put_a(1'b1, 3'd2, 64'h5D9F, 64'hF0CB2, 64'h0);
    cyc();
    put_a(1'b1, 3'd0, 64'hF, 64'h3, 64'h3);
    #1;
    chk("hold_ready_stage", 64'(ifa.in_ready), 64'd0);
    cyc();
    chk("hold_fail", 64'(pa_fail), 64'd1);
    chk("hold_halt", 64'(pa_halt), 64'd1);
    chk("hold_errexp", pa_exp, 64'hF512D);
    chk("hold_erry", pa_y, 64'h0);
    chk("hold_erra", pa_a, 64'h5D9F);
    chk("hold_ready_halt", 64'(ifa.in_ready), 64'd0);
    repeat (3) cyc();
    chk("hold_pass_still0", 64'(pa_pass), 64'd0);
    chk("hold_fail_still1", 64'(pa_fail), 64'd1);
    clr_a = 1'b1;
    #1;
    chk("clr_ready_low", 64'(ifa.in_ready), 64'd0);
    cyc();
    clr_a = 1'b0;
    #1;
    chk("clr_fail", 64'(pa_fail), 64'd0);
    chk("clr_err", 64'(pa_err), 64'd0);
    chk("clr_halt", 64'(pa_halt), 64'd0);
    chk("clr_errexp", pa_exp, 64'd0);
    chk("clr_ready", 64'(ifa.in_ready), 64'd1);
    cyc();
    ifa.in_valid = 1'b0;
    cyc();
    chk("after_clr_pass", 64'(pa_pass), 64'd1);

    // clear drops the tuple sitting in the stage
    pulse_clr_a();
    put_a(1'b1, 3'd3, 64'd1, 64'd1, 64'd7);
    cyc();
    ifa.in_valid = 1'b0;
    clr_a = 1'b1;
    cyc();
    clr_a = 1'b0;
    cyc();
    chk("clr_drop_fail", 64'(pa_fail), 64'd0);
    chk("clr_drop_err", 64'(pa_err), 64'd0);

    // Async reset with the stage holding a tuple
    put_a(1'b1, 3'd1, 64'd1, 64'd2, 64'd3);
    cyc();
    ifa.in_valid = 1'b0;
    cyc();
    chk("pre_rst_pass", 64'(pa_pass), 64'd1);
    ifa.in_valid = 1'b1;
    cyc();
    ifa.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_pass", 64'(pa_pass), 64'd0);
    chk("arst_ready", 64'(ifa.in_ready), 64'd0);
    rst_n = 1'b1;
    cyc(); cyc();
    chk("arst_no_update", 64'(pa_pass), 64'd0);
    chk("arst_ready_back", 64'(ifa.in_ready), 64'd1);

    // Free-running stream: 3 pass, fail(a=1), 2 pass, then fail(a=2)
    pulse_clr_b();
    for (int i = 0; i < 7; i++) begin
      if (i == 3)      put_b(1'b1, 3'd3, 64'd1, 64'd1, 64'd3);
      else if (i == 6) put_b(1'b1, 3'd3, 64'd2, 64'd2, 64'd0);
      else             put_b(1'b1, 3'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'(i + 10), 64'(i + 10));
      cyc();
      if (i == 5) begin
        ifb.in_valid = 1'b0;
        cyc(); cyc();
        chk("stream_pass", 64'(pb_pass), 64'd5);
        chk("stream_fail", 64'(pb_fail), 64'd1);
      end
    end
    ifb.in_valid = 1'b0;
    cyc(); cyc();
    chk("stream_fail2", 64'(pb_fail), 64'd2);
    chk("stream_erra", pb_a, 64'd1);
    chk("stream_errexp", pb_exp, 64'd2);
    chk("stream_nohalt", 64'(pb_halt), 64'd0);

    // Saturation of the 4-bit counter
    pulse_clr_b();
    for (int i = 0; i < 20; i++) begin
      put_b(1'b1, 3'd1, 64'(i), 64'd0, 64'(i));
      cyc();
    end
    ifb.in_valid = 1'b0;
    cyc(); cyc();
    chk("sat_c_pass", 64'(pc_pass), 64'd15);
    chk("sat_b_pass", 64'(pb_pass), 64'd20);
    chk("sat_c_fail", 64'(pc_fail), 64'd0);

    // Randomized stream against the model
    pulse_clr_b();
    model_clear();
    for (int bt = 0; bt < 5; bt++) begin
      for (int n = 0; n < 40; n++) begin
        bit v, lg;
        logic [2:0] op;
        logic [63:0] ra, rb, ry, e;
        v  = ($urandom_range(0, 3) != 0);
        op = 3'($urandom_range(0, 7));
        ra = {$urandom, $urandom};
        rb = ($urandom_range(0, 7) == 0) ? ~ra : {$urandom, $urandom};
        e  = ref_exp(op, ra, rb, lg);
        ry = ($urandom_range(0, 2) != 0) ? e : (e ^ (64'd1 << $urandom_range(0, 63)));
        put_b(v, op, ra, rb, ry);
        #1;
        if (v) begin
          chk("rnd_ready", 64'(ifb.in_ready), 64'd1);
          model_take(op, ra, rb, ry);
        end
        cyc();
      end
      ifb.in_valid = 1'b0;
      cyc(); cyc();
      chk("rnd_pass", 64'(pb_pass), 64'(m_pass));
      chk("rnd_fail", 64'(pb_fail), 64'(m_fail));
      chk("rnd_err", 64'(pb_err), 64'(m_err));
      chk("rnd_errop", 64'(pb_op), 64'(m_op));
      chk("rnd_erra", pb_a, m_a);
      chk("rnd_errexp", pb_exp, m_exp);
      chk("rnd_c_pass", 64'(pc_pass), 64'((m_pass > 15) ? 15 : m_pass));
      chk("rnd_c_fail", 64'(pc_fail), 64'((m_fail > 15) ? 15 : m_fail));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
